// File: rtl/profiler_pkg.sv
// Shared types for the instruction-class profiler:
// class encoding, RV32 major opcodes and the ALU funct3 decode.
package profiler_pkg;

    localparam int NUM_CLASSES = 12;
    localparam int NUM_CNT     = NUM_CLASSES + 1;

    typedef enum logic [3:0] {
        LOAD    = 4'd0,
        STORE   = 4'd1,
        ADD     = 4'd2,
        BITWISE = 4'd3,
        SHIFT   = 4'd4,
        COMPARE = 4'd5,
        BRANCH  = 4'd6,
        JUMP    = 4'd7,
        SYSTEM  = 4'd8,
        ATOMIC  = 4'd9,
        MULDIV  = 4'd10,
        OTHER   = 4'd11
    } instr_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    function automatic instr_class_e alu_class(input logic [2:0] funct3);
        case (funct3)
            3'b000:         alu_class = ADD;
            3'b001, 3'b101: alu_class = SHIFT;
            3'b010, 3'b011: alu_class = COMPARE;
            default:        alu_class = BITWISE;
        endcase
    endfunction

endpackage

// File: rtl/rv_instr_classifier.sv
// Combinational RV32 instruction -> profiling class decode.
// Every encoding maps to exactly one class.
module rv_instr_classifier
    import profiler_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e class_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        class_o = OTHER;
        case (opcode)
            OPC_LOAD:           class_o = LOAD;
            OPC_STORE:          class_o = STORE;
            OPC_BRANCH:         class_o = BRANCH;
            OPC_JAL, OPC_JALR:  class_o = JUMP;
            OPC_SYSTEM:         class_o = SYSTEM;
            OPC_AMO:            class_o = ATOMIC;
            OPC_OP: begin
                if (funct7 == F7_MULDIV) class_o = MULDIV;
                else                     class_o = alu_class(funct3);
            end
            OPC_OPIMM:          class_o = alu_class(funct3);
            OPC_LUI, OPC_AUIPC: class_o = ADD;
            default:            class_o = OTHER;
        endcase
    end

endmodule

// File: rtl/instr_class_profiler.sv
// Multi-lane instruction-class profiler: live counters with overflow
// flags, a snapshot shadow bank and a registered indexed read port.
module instr_class_profiler
    import profiler_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int LANES    = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [LANES*32-1:0]    instr,
    input  logic [LANES-1:0]       instr_valid,
    input  logic                   snap_req,
    output logic                   snap_valid,
    input  logic [3:0]             rd_sel,
    output logic [CNT_W-1:0]       rd_data,
    output logic [NUM_CLASSES:0]   ovf_flags
);

    instr_class_e cls [LANES];

    logic [2:0]       inc   [NUM_CNT];
    logic [CNT_W:0]   sum   [NUM_CNT];
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [CNT_W-1:0] shd_q [NUM_CNT];
    logic [NUM_CLASSES:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic             snap_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rv_instr_classifier u_cls (
            .instr_i (instr[32*g +: 32]),
            .class_o (cls[g])
        );
    end

    // Lane hits per class; the last slot counts every valid lane
    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) inc[k] = 3'd0;
        for (int l = 0; l < LANES; l++) begin
            if (instr_valid[l]) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    if (cls[l] == instr_class_e'(k)) inc[k] = inc[k] + 3'd1;
                end
                inc[NUM_CLASSES] = inc[NUM_CLASSES] + 3'd1;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < NUM_CNT; k++) begin
            sum[k]   = {1'b0, cnt_q[k]} + {{(CNT_W-2){1'b0}}, inc[k]};
            cnt_d[k] = cnt_q[k];
            if (clear) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (enable) begin
                if (sum[k][CNT_W]) begin
                    cnt_d[k] = SATURATE ? {CNT_W{1'b1}} : sum[k][CNT_W-1:0];
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = sum[k][CNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel == 4'(k)) rd_d = shd_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
                shd_q[k] <= '0;
            end
            ovf_q  <= '0;
            rd_q   <= '0;
            snap_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
                // Shadow captures pre-update values, so clear+snap keeps the old counts
                if (snap_req) shd_q[k] <= cnt_q[k];
            end
            ovf_q  <= ovf_d;
            rd_q   <= rd_d;
            snap_q <= snap_req;
        end
    end

    assign snap_valid = snap_q;
    assign rd_data    = rd_q;
    assign ovf_flags  = ovf_q;

endmodule

// File: tb/tb_instr_class_profiler.sv
// Directed bench for instr_class_profiler: a 32-bit saturating DUT
// plus 8-bit saturating and wrapping DUTs for the overflow cases.
module tb_instr_class_profiler;
    import profiler_pkg::*;

    localparam logic [31:0] I_LW    = 32'h0000_2003;
    localparam logic [31:0] I_ADDI  = 32'h0000_0013;
    localparam logic [31:0] I_SLLI  = 32'h0000_1013;
    localparam logic [31:0] I_SLTU  = 32'h0000_3033;
    localparam logic [31:0] I_XOR   = 32'h0000_4033;
    localparam logic [31:0] I_MUL   = 32'h0200_0033;
    localparam logic [31:0] I_JALR  = 32'h0000_0067;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_AMO   = 32'h0000_202F;
    localparam logic [31:0] I_BAD   = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst, enable, en8, clear, snap_req;
    logic [63:0] instr;
    logic [1:0]  valid, v8;
    logic [3:0]  rd_sel;
    logic        sv_m, sv_s, sv_w;
    logic [31:0] rd_m;
    logic [7:0]  rd_s, rd_w;
    logic [12:0] ovf_m, ovf_s, ovf_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_class_profiler #(.CNT_W(32), .LANES(2), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .instr(instr), .instr_valid(valid), .snap_req(snap_req),
        .snap_valid(sv_m), .rd_sel(rd_sel), .rd_data(rd_m),
        .ovf_flags(ovf_m)
    );

    instr_class_profiler #(.CNT_W(8), .LANES(2), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .enable(en8), .clear(clear),
        .instr(instr), .instr_valid(v8), .snap_req(snap_req),
        .snap_valid(sv_s), .rd_sel(rd_sel), .rd_data(rd_s),
        .ovf_flags(ovf_s)
    );

    instr_class_profiler #(.CNT_W(8), .LANES(2), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .enable(en8), .clear(clear),
        .instr(instr), .instr_valid(v8), .snap_req(snap_req),
        .snap_valid(sv_w), .rd_sel(rd_sel), .rd_data(rd_w),
        .ovf_flags(ovf_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap(input string tag);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        chk({tag, "_snap_valid"}, 32'(sv_m), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [3:0] sel,
                      input logic [31:0] exp);
        rd_sel = sel;
        step();
        chk(tag, rd_m, exp);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; en8 = 1'b0; clear = 1'b0;
        snap_req = 1'b0; instr = '0; valid = 2'b00; v8 = 2'b00;
        rd_sel = 4'd0;
        step(2);
        chk("rst_snap_valid", 32'(sv_m), 32'd0);
        chk("rst_rd_data", rd_m, 32'd0);
        chk("rst_ovf", 32'(ovf_m), 32'd0);
        rst = 1'b0;
        step();

        // 1: LW + ADDI for 10 cycles
        enable = 1'b1;
        instr = {I_ADDI, I_LW};
        valid = 2'b11;
        step(10);
        valid = 2'b00;
        snap("t1");
        rd("t1_load", 4'd0, 32'd10);
        chk("t1_snap_pulse_done", 32'(sv_m), 32'd0);
        rd("t1_add", 4'd2, 32'd10);
        rd("t1_total", 4'd12, 32'd20);
        rd("t1_store", 4'd1, 32'd0);
        chk("t1_ovf", 32'(ovf_m), 32'd0);

        // 2: one of each remaining class
        clear = 1'b1; step(); clear = 1'b0;
        valid = 2'b11;
        instr = {I_SLTU, I_SLLI};   step();
        instr = {I_MUL, I_XOR};     step();
        instr = {I_ECALL, I_JALR};  step();
        instr = {I_BAD, I_AMO};     step();
        valid = 2'b00;
        snap("t2");
        rd("t2_shift", 4'd4, 32'd1);
        rd("t2_compare", 4'd5, 32'd1);
        rd("t2_bitwise", 4'd3, 32'd1);
        rd("t2_muldiv", 4'd10, 32'd1);
        rd("t2_jump", 4'd7, 32'd1);
        rd("t2_system", 4'd8, 32'd1);
        rd("t2_atomic", 4'd9, 32'd1);
        rd("t2_other", 4'd11, 32'd1);
        rd("t2_total", 4'd12, 32'd8);
        rd("t2_load", 4'd0, 32'd0);
        rd("t2_add", 4'd2, 32'd0);

        // 3: 300 loads into the 8-bit DUTs
        enable = 1'b0;
        en8 = 1'b1;
        instr = {I_LW, I_LW};
        v8 = 2'b11;
        step(150);
        v8 = 2'b00;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        chk("t3_sat_snap_valid", 32'(sv_s), 32'd1);
        rd_sel = 4'd0; step();
        chk("t3_sat_load", 32'(rd_s), 32'd255);
        chk("t3_wrap_load", 32'(rd_w), 32'd44);
        rd_sel = 4'd12; step();
        chk("t3_sat_total", 32'(rd_s), 32'd255);
        chk("t3_wrap_total", 32'(rd_w), 32'd44);
        chk("t3_sat_ovf", 32'(ovf_s), 32'h1001);
        chk("t3_wrap_ovf", 32'(ovf_w), 32'h1001);

        // 4: enable low holds; clear drops same-cycle lanes
        en8 = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        chk("t4_sat_ovf_cleared", 32'(ovf_s), 32'd0);
        enable = 1'b1;
        instr = {I_ADDI, I_LW};
        valid = 2'b11;
        step(3);
        enable = 1'b0;
        step(5);
        snap("t4a");
        rd("t4_hold_load", 4'd0, 32'd3);
        rd("t4_hold_total", 4'd12, 32'd6);
        enable = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        valid = 2'b00;
        chk("t4_clear_ovf", 32'(ovf_m), 32'd0);
        snap("t4b");
        rd("t4_clear_load", 4'd0, 32'd0);
        rd("t4_clear_total", 4'd12, 32'd0);

        // 5: clear and snapshot in the same cycle
        instr = {I_ADDI, I_LW};
        valid = 2'b01;
        step(7);
        valid = 2'b00;
        clear = 1'b1;
        snap("t5a");
        clear = 1'b0;
        rd("t5_pre_clear_load", 4'd0, 32'd7);
        snap("t5b");
        rd("t5_live_load", 4'd0, 32'd0);

        // 6: out-of-range reads, then reset with a pending snapshot
        valid = 2'b01;
        step(3);
        valid = 2'b00;
        snap("t6");
        rd("t6_load", 4'd0, 32'd3);
        rd("t6_sel13", 4'd13, 32'd0);
        rd("t6_sel15", 4'd15, 32'd0);
        rd_sel = 4'd0;
        step();
        chk("t6_pre_rst_rd", rd_m, 32'd3);
        valid = 2'b11;
        rst = 1'b1;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        valid = 2'b00;
        chk("t6_rst_snap_valid", 32'(sv_m), 32'd0);
        chk("t6_rst_rd_data", rd_m, 32'd0);
        chk("t6_rst_ovf", 32'(ovf_m), 32'd0);
        rst = 1'b0;
        rd("t6_rst_shadow", 4'd0, 32'd0);
        rd("t6_rst_sel13", 4'd13, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
